// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_CNT_W          = 8;

  // Largest of three sizes; used to size the shared sequence counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Increment v unless it already holds the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a synchronous active-low clear.
module sync_2ff (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two capture stages; clear zeroes both so the output restarts from 0.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for and qualifies lock,
// then releases the downstream system reset. Recovers from timeouts and
// lock loss, and re-runs the sequence on a software request.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             sw_reset,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt,
  output logic             timeout_flag
);

  localparam int CW = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CW-1:0] LD_RST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LD_WAIT   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LD_STABLE = CW'(STABLE_CYCLES - 1);

  pll_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             tflag_q, tflag_d;
  logic             pll_rst_q, sys_rst_n_q, ready_q;
  logic             lk;
  logic             sync_clr_n;

  // A PLL held in reset reports nothing meaningful on locked, so the
  // synchronizer is held clear during PLL_RST: every lock attempt then
  // starts from lk=0 and pays the same two-cycle synchronizer delay.
  assign sync_clr_n = rst & (state_q != PLL_RST);

  sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .clr_ni (sync_clr_n),
    .d_i    (pll_locked),
    .q_o    (lk)
  );

  // Next-state, counter reload and event-counter updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    loss_d  = loss_q;
    retry_d = retry_q;
    tflag_d = tflag_q;
    if (sw_reset) begin
      state_d = PLL_RST;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == '0) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Lock seen on the timeout cycle still wins.
          if (lk) begin
            state_d = STABLE;
          end else if (cnt_q == '0) begin
            state_d = PLL_RST;
            retry_d = CNT_W'(sat_inc(32'(retry_q), CNT_W));
            tflag_d = 1'b1;
          end
        end
        STABLE: begin
          if (!lk)               state_d = WAIT_LOCK;
          else if (cnt_q == '0)  state_d = RUN;
        end
        RUN: begin
          if (!lk) begin
            state_d = PLL_RST;
            loss_d  = CNT_W'(sat_inc(32'(loss_q), CNT_W));
          end
        end
        default: state_d = PLL_RST;
      endcase
    end
    // Reload on every entry; sw_reset in PLL_RST counts as a re-entry.
    if (sw_reset || (state_d != state_q)) begin
      case (state_d)
        PLL_RST:   cnt_d = LD_RST;
        WAIT_LOCK: cnt_d = LD_WAIT;
        STABLE:    cnt_d = LD_STABLE;
        default:   cnt_d = '0;
      endcase
    end
  end

  // State, counters and registered Moore output decodes.
  // Reset is treated as an entry into PLL_RST, so the hold count is loaded.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q     <= PLL_RST;
      cnt_q       <= LD_RST;
      loss_q      <= '0;
      retry_q     <= '0;
      tflag_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      tflag_q     <= tflag_d;
      pll_rst_q   <= (state_d == PLL_RST);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;
  assign timeout_flag  = tflag_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl (PLL_RST=4, TIMEOUT=20, STABLE=8).
// A second instance with CNT_W=2 shares all inputs to cover saturation.
module tb_pll_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_reset = 1'b0;
  logic       pll_rst, sys_rst_n, ready, timeout_flag;
  logic [7:0] lock_loss_cnt, retry_cnt;
  logic       pll_rst2, sys_rst_n2, ready2, timeout_flag2;
  logic [1:0] lock_loss_cnt2, retry_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 refclk = ~refclk;

  pll_reset_ctrl #(.PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .CNT_W(8)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_reset(sw_reset),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
    .lock_loss_cnt(lock_loss_cnt), .retry_cnt(retry_cnt), .timeout_flag(timeout_flag)
  );

  pll_reset_ctrl #(.PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .CNT_W(2)) dut2 (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_reset(sw_reset),
    .pll_rst(pll_rst2), .sys_rst_n(sys_rst_n2), .ready(ready2),
    .lock_loss_cnt(lock_loss_cnt2), .retry_cnt(retry_cnt2), .timeout_flag(timeout_flag2)
  );

  // Advance k active edges and settle just after the last one.
  task automatic step(input int k = 1);
    repeat (k) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pll_locked = 1'b1; sw_reset = 1'b0;
    step(3);
    n_tests++;
    if ({pll_rst, sys_rst_n, ready, timeout_flag, lock_loss_cnt, retry_cnt} !== {4'b1000, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_values got %b%b%b%b %h %h want 1000 00 00", pll_rst, sys_rst_n, ready,
               timeout_flag, lock_loss_cnt, retry_cnt);
    end
  endtask

  // Locked PLL: pll_rst drops at edge 4, system released at edge 15.
  task automatic test_release();
    logic [2:0] e;
    rst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      e = {n < 4, n >= 15, n >= 15};
      n_tests++;
      if ({pll_rst, sys_rst_n, ready, lock_loss_cnt, retry_cnt, timeout_flag} !== {e, 17'h0}) begin
        n_fail++;
        $display("FAIL release n=%0d got %b%b%b ll=%0d rt=%0d tf=%b want %b 0 0 0", n, pll_rst,
                 sys_rst_n, ready, lock_loss_cnt, retry_cnt, timeout_flag, e);
      end
    end
  endtask

  // Lock drop in RUN is seen 3 edges later; relock repeats the release latency.
  task automatic test_lock_loss();
    logic [2:0] e;
    pll_locked = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      step();
      e = {m == 3, m < 3, m < 3};
      n_tests++;
      if ({pll_rst, sys_rst_n, ready, lock_loss_cnt} !== {e, 8'(m == 3)}) begin
        n_fail++;
        $display("FAIL lock_loss_drop m=%0d got %b%b%b ll=%0d want %b ll=%0d", m, pll_rst, sys_rst_n,
                 ready, lock_loss_cnt, e, (m == 3));
      end
    end
    pll_locked = 1'b1;
    for (int m = 1; m <= 15; m++) begin
      step();
      e = {m < 4, m >= 15, m >= 15};
      n_tests++;
      if ({pll_rst, sys_rst_n, ready, lock_loss_cnt, retry_cnt} !== {e, 8'd1, 8'd0}) begin
        n_fail++;
        $display("FAIL lock_loss_relock m=%0d got %b%b%b ll=%0d rt=%0d want %b ll=1 rt=0", m, pll_rst,
                 sys_rst_n, ready, lock_loss_cnt, retry_cnt, e);
      end
    end
  endtask

  // Two-cycle lock dropout at STABLE cnt=3: release moves from edge 15 to 24.
  task automatic test_stable_glitch();
    logic [2:0] e;
    rst = 1'b0; pll_locked = 1'b1;
    step(2);
    rst = 1'b1;
    step(11);
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    for (int n = 14; n <= 24; n++) begin
      step();
      e = {1'b0, n >= 24, n >= 24};
      n_tests++;
      if ({pll_rst, sys_rst_n, ready, lock_loss_cnt, retry_cnt, timeout_flag} !== {e, 17'h0}) begin
        n_fail++;
        $display("FAIL stable_glitch n=%0d got %b%b%b ll=%0d rt=%0d tf=%b want %b 0 0 0", n, pll_rst,
                 sys_rst_n, ready, lock_loss_cnt, retry_cnt, timeout_flag, e);
      end
    end
  endtask

  // No lock: 24-cycle retry period, retry_cnt 1,2,3, sticky flag.
  task automatic test_timeout();
    rst = 1'b0; pll_locked = 1'b0;
    step(2);
    rst = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      step();
      n_tests++;
      if ({pll_rst, sys_rst_n, ready, retry_cnt, timeout_flag, lock_loss_cnt} !==
          {(n % 24) < 4, 2'b00, 8'(n / 24), n >= 24, 8'd0}) begin
        n_fail++;
        $display("FAIL timeout n=%0d got pr=%b sr=%b rd=%b rt=%0d tf=%b want pr=%b sr=0 rd=0 rt=%0d tf=%b",
                 n, pll_rst, sys_rst_n, ready, retry_cnt, timeout_flag, (n % 24) < 4, n / 24, n >= 24);
      end
    end
  endtask

  // Reach RUN with timeout history, then sw_reset, restart, and rst pulse.
  task automatic test_sw_reset();
    pll_locked = 1'b1;
    for (int n = 76; n <= 87; n++) begin
      step();
      n_tests++;
      if ({sys_rst_n, ready, retry_cnt, timeout_flag} !== {n >= 87, n >= 87, 8'd3, 1'b1}) begin
        n_fail++;
        $display("FAIL late_lock n=%0d got sr=%b rd=%b rt=%0d tf=%b want sr=%b rt=3 tf=1", n,
                 sys_rst_n, ready, retry_cnt, timeout_flag, n >= 87);
      end
    end
    sw_reset = 1'b1; step(); sw_reset = 1'b0;
    n_tests++;
    if ({pll_rst, sys_rst_n, ready, retry_cnt, timeout_flag, lock_loss_cnt} !== {3'b100, 8'd3, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL sw_reset_run got %b%b%b rt=%0d tf=%b ll=%0d want 100 rt=3 tf=1 ll=0", pll_rst,
               sys_rst_n, ready, retry_cnt, timeout_flag, lock_loss_cnt);
    end
    step(2);
    sw_reset = 1'b1; step(); sw_reset = 1'b0;
    for (int m = 1; m <= 4; m++) begin
      step();
      n_tests++;
      if (pll_rst !== (m < 4)) begin
        n_fail++;
        $display("FAIL sw_restart m=%0d got pr=%b want %b", m, pll_rst, m < 4);
      end
    end
    rst = 1'b0; step();
    n_tests++;
    if ({pll_rst, sys_rst_n, ready, timeout_flag, retry_cnt, lock_loss_cnt} !== {4'b1000, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_mid got %b%b%b tf=%b rt=%0d ll=%0d want 100 tf=0 rt=0 ll=0", pll_rst,
               sys_rst_n, ready, timeout_flag, retry_cnt, lock_loss_cnt);
    end
    rst = 1'b1;
    step(14);
    n_tests++;
    if (sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_early got sr=%b want 0", sys_rst_n);
    end
    step();
    n_tests++;
    if ({sys_rst_n, ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid_release got %b%b want 11", sys_rst_n, ready);
    end
  endtask

  // Five lock losses: 8-bit counter reaches 5, 2-bit counter sticks at 3.
  task automatic test_saturate();
    rst = 1'b0; pll_locked = 1'b1;
    step(2);
    rst = 1'b1;
    step(15);
    for (int i = 1; i <= 5; i++) begin
      pll_locked = 1'b0;
      step(3);
      n_tests++;
      if ({pll_rst, pll_rst2, lock_loss_cnt, lock_loss_cnt2, retry_cnt2} !==
          {2'b11, 8'(i), 2'(i > 3 ? 3 : i), 2'd0}) begin
        n_fail++;
        $display("FAIL saturate i=%0d got pr=%b%b ll=%0d ll2=%0d rt2=%0d want pr=11 ll=%0d ll2=%0d rt2=0",
                 i, pll_rst, pll_rst2, lock_loss_cnt, lock_loss_cnt2, retry_cnt2, i, (i > 3 ? 3 : i));
      end
      pll_locked = 1'b1;
      step(15);
      n_tests++;
      if ({ready, ready2} !== 2'b11) begin
        n_fail++;
        $display("FAIL saturate_run i=%0d got %b%b want 11", i, ready, ready2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_lock_loss();
    test_stable_glitch();
    test_timeout();
    test_sw_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
